// File: rtl/imm_narrower_if.sv
// Handshake bundle for imm_narrower: producer stream in, packed immediates out,
// plus the overflow counter controls.
interface imm_narrower_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 12,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, in_data, sat_en, out_ready, clr_count,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_data, sat_en, out_ready, clr_count,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface

// File: rtl/imm_narrower.sv
// Narrows 32-bit two's-complement values to 12-bit signed immediates, flagging
// overflow (truncate or saturate), behind a 2-entry output buffer.
module imm_narrower #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 12,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_narrower_if.slave bus
);
    logic [OUT_W-1:0] r_head_data, r_tail_data;
    logic             r_head_ovf, r_tail_ovf;
    logic [1:0]       r_occ;
    logic [CNT_W-1:0] r_ovf_count;

    logic [OUT_W-1:0] w_head_data, w_tail_data;
    logic             w_head_ovf, w_tail_ovf;
    logic [1:0]       w_occ;
    logic [CNT_W-1:0] w_cnt_base, w_ovf_count;
    logic [OUT_W:0]   w_enc;
    logic             w_push, w_pop;

    // Returns {ovf, data}; a value fits when all bits from the sign bit down to OUT_W-1 agree.
    function automatic logic [OUT_W:0] narrow(input logic [IN_W-1:0] val, input logic sat);
        logic [IN_W-OUT_W:0] upper;
        logic                fit;
        logic [OUT_W:0]      res;
        upper = val[IN_W-1:OUT_W-1];
        fit   = (&upper) | ~(|upper);
        if (fit) begin
            res = {1'b0, val[OUT_W-1:0]};
        end else if (sat) begin
            res = {1'b1, val[IN_W-1], {(OUT_W-1){~val[IN_W-1]}}};
        end else begin
            res = {1'b1, val[OUT_W-1:0]};
        end
        return res;
    endfunction

    assign w_enc         = narrow(bus.in_data, bus.sat_en);
    assign bus.in_ready  = (r_occ != 2'd2);
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_head_data;
    assign bus.out_ovf   = r_head_ovf;
    assign bus.ovf_count = r_ovf_count;
    assign w_push        = bus.in_valid & (r_occ != 2'd2);
    assign w_pop         = bus.out_ready & (r_occ != 2'd0);

    // Buffer next-state: head is always the oldest entry, tail only used at occupancy 2.
    always_comb begin
        w_occ       = r_occ;
        w_head_data = r_head_data;
        w_head_ovf  = r_head_ovf;
        w_tail_data = r_tail_data;
        w_tail_ovf  = r_tail_ovf;
        case (r_occ)
            2'd0: begin
                if (w_push) begin
                    {w_head_ovf, w_head_data} = w_enc;
                    w_occ = 2'd1;
                end else begin
                    w_occ = 2'd0;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    {w_head_ovf, w_head_data} = w_enc;
                end else if (w_push) begin
                    {w_tail_ovf, w_tail_data} = w_enc;
                    w_occ = 2'd2;
                end else if (w_pop) begin
                    w_occ = 2'd0;
                end else begin
                    w_occ = 2'd1;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    w_head_data = r_tail_data;
                    w_head_ovf  = r_tail_ovf;
                    w_occ       = 2'd1;
                end else begin
                    w_occ = 2'd2;
                end
            end
            default: begin
                w_occ = 2'd0;
            end
        endcase
    end

    // Overflow counter next-state: clear first, then a saturating increment.
    always_comb begin
        w_cnt_base  = bus.clr_count ? {CNT_W{1'b0}} : r_ovf_count;
        w_ovf_count = w_cnt_base;
        if (w_push && w_enc[OUT_W] && !(&w_cnt_base)) begin
            w_ovf_count = w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_ovf_count = w_cnt_base;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ       <= 2'd0;
            r_head_data <= {OUT_W{1'b0}};
            r_head_ovf  <= 1'b0;
            r_tail_data <= {OUT_W{1'b0}};
            r_tail_ovf  <= 1'b0;
            r_ovf_count <= {CNT_W{1'b0}};
        end else begin
            r_occ       <= w_occ;
            r_head_data <= w_head_data;
            r_head_ovf  <= w_head_ovf;
            r_tail_data <= w_tail_data;
            r_tail_ovf  <= w_tail_ovf;
            r_ovf_count <= w_ovf_count;
        end
    end
endmodule

// File: doc/imm_narrower.md
Name: imm_narrower

Overview:
- Inverse of the immediate sign-extension path: takes 32-bit two's-complement values and packs each into a 12-bit signed immediate field.
- Flags values that do not fit in 12 bits and either truncates or saturates them.
- Sits between the assembler/immediate-generation stream and instruction-word assembly.
- Valid/ready handshake on both sides, 2-entry output buffer, running overflow counter.

Parameters:
- IN_W, 32, input value width.
- OUT_W, 12, packed immediate width; fits iff in_data[IN_W-1:OUT_W-1] are all equal.
- CNT_W, 16, overflow counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_W  value to narrow.
- sat_en  input  1  1 = saturate on overflow, 0 = truncate; sampled with the accepted word.
- out_valid  output  1  out_data/out_ovf hold a valid entry.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_data  output  OUT_W  packed immediate.
- out_ovf  output  1  head entry did not fit in OUT_W signed.
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  number of accepted overflowing words, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - buffer emptied; out_valid=0, out_data=0, out_ovf=0, ovf_count=0.
  - in_ready=1 while in reset, but the block accepts nothing until rst_n is high at a rising edge.
  - Reset mid-transfer discards all buffered entries.
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Fit check on the accepted word: fit = (in_data[IN_W-1:OUT_W-1] all 0s or all 1s).
- Encoding at acceptance:
  - fit: data=in_data[OUT_W-1:0], ovf=0.
  - not fit, sat_en=1: data=0x800 if in_data[IN_W-1]=1, else 0x7FF; ovf=1.
  - not fit, sat_en=0: data=in_data[OUT_W-1:0], ovf=1.
- Buffer: 2-entry FIFO.
  - in_ready = (occupancy != 2), derived from registered occupancy only, never from out_ready.
  - out_valid = (occupancy != 0); out_data/out_ovf show the head entry.
  - out_data/out_ovf are held stable while out_valid=1 and out_ready=0.
  - Latency: a word accepted at edge N is visible on out_* after edge N when the buffer was empty. No combinational in-to-out path.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Full (2): no push, even if out_ready=1 in the same cycle.
  - Empty: out_ready is ignored.
- ovf_count:
  - Increments on each accepted word with ovf=1.
  - Saturates at all-ones (0xFFFF) and never wraps.
  - clr_count=1: count becomes 0, plus 1 if an overflowing word is accepted in the same cycle.
- Invariant: whenever out_ovf=0, sign-extending out_data to 32 bits reproduces the original in_data exactly.

Test Plan:
- In-range values: push 0x00000005, 0xFFFFF800, 0x000007FF with out_ready=1.
  - Required: out_data 0x005, 0x800, 0x7FF; out_ovf=0; each appears 1 cycle after acceptance; ovf_count=0.
- Overflow with saturation: sat_en=1, push 0x00000800 then 0xFFFFF7FF.
  - Required: out_data 0x7FF then 0x800; out_ovf=1 for both; ovf_count=2.
- Overflow with truncation: sat_en=0, push 0x12345ABC.
  - Required: out_data=0xABC, out_ovf=1, ovf_count increments by 1.
- Backpressure: out_ready=0, push 3 words back-to-back.
  - Required: in_ready drops after the 2nd accept; the 3rd word is held by the producer; head stays stable.
  - Then raise out_ready: words appear in order with no loss or duplication. Also check simultaneous push/pop at occupancy 1 keeps occupancy at 1.
- Counter edges:
  - Preload to 0xFFFE via overflow words, then 3 more overflow words; required: ovf_count holds 0xFFFF.
  - clr_count together with an overflowing accept; required: ovf_count=1.
- Reset mid-operation: assert rst_n=0 between clock edges with 2 entries buffered.
  - Required: out_valid=0 and ovf_count=0 immediately, before the next clock edge.
  - After release: the next accepted word is the first word output.
- Random: 10k random words with random sat_en and out_ready.
  - Required: the scoreboard matches the encoding rules, and the round-trip invariant holds for every entry with ovf=0.
